// File: rtl/qspi_pad_arbiter.sv
// ============================================================================
// Module   : qspi_pad_arbiter
// Brief    : Shares the QSPI0 pad group between two masters with idle gaps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_pad_arbiter #(
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       sck0,
  input  logic       sck1,
  input  logic       cs0,
  input  logic       cs1,
  input  logic [3:0] dq_o0,
  input  logic [3:0] dq_o1,
  input  logic [3:0] dq_oe0,
  input  logic [3:0] dq_oe1,
  output logic [3:0] dq_i0,
  output logic [3:0] dq_i1,
  output logic       pad_sck,
  output logic       pad_cs,
  output logic [3:0] pad_dq_o,
  output logic [3:0] pad_dq_oe,
  input  logic [3:0] pad_dq_i,
  output logic       busy
);

  localparam int CW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_GNT0 = 2'd1;
  localparam logic [1:0] c_GNT1 = 2'd2;
  localparam logic [1:0] c_GAP  = 2'd3;

  localparam logic [CW-1:0] c_GAP_LOAD = CW'(GAP_CYCLES - 1);

  logic [1:0]    r_state;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic [1:0]    w_arb;

  // Tie goes to the port that did not own the pads last.
  always_comb begin
    w_arb = c_IDLE;
    if (req0 && req1) begin
      w_arb = r_last ? c_GNT0 : c_GNT1;
    end else if (req0) begin
      w_arb = c_GNT0;
    end else if (req1) begin
      w_arb = c_GNT1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: r_state <= w_arb;
        c_GNT0: begin
          if (!req0 && cs0) begin
            r_state <= c_GAP;
            r_cnt   <= c_GAP_LOAD;
            r_last  <= 1'b0;
          end
        end
        c_GNT1: begin
          if (!req1 && cs1) begin
            r_state <= c_GAP;
            r_cnt   <= c_GAP_LOAD;
            r_last  <= 1'b1;
          end
        end
        c_GAP: begin
          if (r_cnt == '0) begin
            r_state <= w_arb;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign gnt0 = (r_state == c_GNT0);
  assign gnt1 = (r_state == c_GNT1);
  assign busy = (r_state != c_IDLE);

  // Mux select comes only from registered state; data path is combinational.
  always_comb begin
    pad_sck   = 1'b0;
    pad_cs    = 1'b1;
    pad_dq_o  = 4'h0;
    pad_dq_oe = 4'h0;
    dq_i0     = 4'hF;
    dq_i1     = 4'hF;
    if (gnt0) begin
      pad_sck   = sck0;
      pad_cs    = cs0;
      pad_dq_o  = dq_o0;
      pad_dq_oe = dq_oe0;
      dq_i0     = pad_dq_i;
    end else if (gnt1) begin
      pad_sck   = sck1;
      pad_cs    = cs1;
      pad_dq_o  = dq_o1;
      pad_dq_oe = dq_oe1;
      dq_i1     = pad_dq_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qspi_pad_arbiter.sv
// ============================================================================
// Module   : tb_qspi_pad_arbiter
// Brief    : Directed self-checking bench for qspi_pad_arbiter (GAP 4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qspi_pad_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, sck0, sck1, cs0, cs1;
  logic [3:0] dq_o0, dq_o1, dq_oe0, dq_oe1, pad_dq_i;

  logic       gnt0, gnt1, pad_sck, pad_cs, busy;
  logic [3:0] dq_i0, dq_i1, pad_dq_o, pad_dq_oe;

  logic       b_gnt0, b_gnt1, b_pad_sck, b_pad_cs, b_busy;
  logic [3:0] b_dq_i0, b_dq_i1, b_pad_dq_o, b_pad_dq_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qspi_pad_arbiter #(.GAP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .sck0(sck0), .sck1(sck1),
    .cs0(cs0), .cs1(cs1), .dq_o0(dq_o0), .dq_o1(dq_o1),
    .dq_oe0(dq_oe0), .dq_oe1(dq_oe1), .dq_i0(dq_i0), .dq_i1(dq_i1),
    .pad_sck(pad_sck), .pad_cs(pad_cs), .pad_dq_o(pad_dq_o),
    .pad_dq_oe(pad_dq_oe), .pad_dq_i(pad_dq_i), .busy(busy)
  );

  qspi_pad_arbiter #(.GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .sck0(sck0), .sck1(sck1),
    .cs0(cs0), .cs1(cs1), .dq_o0(dq_o0), .dq_o1(dq_o1),
    .dq_oe0(dq_oe0), .dq_oe1(dq_oe1), .dq_i0(b_dq_i0), .dq_i1(b_dq_i1),
    .pad_sck(b_pad_sck), .pad_cs(b_pad_cs), .pad_dq_o(b_pad_dq_o),
    .pad_dq_oe(b_pad_dq_oe), .pad_dq_i(pad_dq_i), .busy(b_busy)
  );

  // Grants must be exclusive in both builds at every sample point.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if ((gnt0 & gnt1) !== 1'b0 || (b_gnt0 & b_gnt1) !== 1'b0) begin
        bad++;
        $display("FAIL gnt_exclusive: got g4=%b%b g1=%b%b expected never 11",
                 gnt0, gnt1, b_gnt0, b_gnt1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 0; req1 = 0; sck0 = 0; sck1 = 0; cs0 = 1; cs1 = 1;
    dq_o0 = 4'h0; dq_o1 = 4'h0; dq_oe0 = 4'h0; dq_oe1 = 4'h0; pad_dq_i = 4'h5;
    tick(1);
    total++;
    if ({gnt0, gnt1, busy, pad_cs, pad_sck, pad_dq_o, pad_dq_oe, dq_i0, dq_i1}
        !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF}) begin
      bad++;
      $display("FAIL reset_state: got gnt=%b%b busy=%b cs=%b sck=%b o=%h oe=%h i0=%h i1=%h expected 00 0 1 0 0 0 f f",
               gnt0, gnt1, busy, pad_cs, pad_sck, pad_dq_o, pad_dq_oe, dq_i0, dq_i1);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_grant();
    req0 = 1'b1;
    tick(1);
    total++;
    if ({gnt0, gnt1, busy} !== 3'b101) begin
      bad++;
      $display("FAIL grant0_latency: got gnt=%b%b busy=%b expected gnt=10 busy=1", gnt0, gnt1, busy);
    end
    cs0 = 1'b0; sck0 = 1'b1; dq_o0 = 4'hA; dq_oe0 = 4'h3;
    #1;
    total++;
    if ({pad_cs, pad_sck, pad_dq_o, pad_dq_oe, dq_i0, dq_i1}
        !== {1'b0, 1'b1, 4'hA, 4'h3, 4'h5, 4'hF}) begin
      bad++;
      $display("FAIL pad_follow0: got cs=%b sck=%b o=%h oe=%h i0=%h i1=%h expected 0 1 a 3 5 f",
               pad_cs, pad_sck, pad_dq_o, pad_dq_oe, dq_i0, dq_i1);
    end
  endtask

  task automatic test_isolation();
    sck0 = 1'b0; sck1 = 1'b1; cs1 = 1'b0; dq_oe1 = 4'hF; dq_o1 = 4'hF;
    #1;
    total++;
    if ({pad_cs, pad_sck, pad_dq_o, pad_dq_oe, dq_i1} !== {1'b0, 1'b0, 4'hA, 4'h3, 4'hF}) begin
      bad++;
      $display("FAIL isolation_owned: got cs=%b sck=%b o=%h oe=%h i1=%h expected 0 0 a 3 f",
               pad_cs, pad_sck, pad_dq_o, pad_dq_oe, dq_i1);
    end
  endtask

  task automatic test_no_preempt();
    req1 = 1'b1;
    tick(1);
    req0 = 1'b0;
    tick(3);
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL no_preempt: got gnt=%b%b expected 10 while cs0 low", gnt0, gnt1);
    end
    cs0 = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({gnt0, gnt1, busy, pad_cs, pad_sck, pad_dq_oe} !== {3'b001, 1'b1, 1'b0, 4'h0}) begin
        bad++;
        $display("FAIL gap_idle[%0d]: got gnt=%b%b busy=%b cs=%b sck=%b oe=%h expected 00 1 1 0 0",
                 i, gnt0, gnt1, busy, pad_cs, pad_sck, pad_dq_oe);
      end
      tick(1);
    end
    total++;
    if ({gnt0, gnt1, pad_cs, pad_sck, pad_dq_oe} !== {2'b01, 1'b0, 1'b1, 4'hF}) begin
      bad++;
      $display("FAIL handover1: got gnt=%b%b cs=%b sck=%b oe=%h expected 01 0 1 f",
               gnt0, gnt1, pad_cs, pad_sck, pad_dq_oe);
    end
    req1 = 1'b0; cs1 = 1'b1; sck1 = 1'b0;
    tick(5);
    total++;
    if ({gnt0, gnt1, busy} !== 3'b000) begin
      bad++;
      $display("FAIL back_to_idle: got gnt=%b%b busy=%b expected 00 0", gnt0, gnt1, busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL rr_owner[%0d]: got gnt=%b%b expected %s", k, gnt0, gnt1,
                 (k % 2 == 0) ? "10" : "01");
      end
      if (k % 2 == 0) req0 = 1'b0; else req1 = 1'b0;
      tick(1);
      req0 = 1'b1; req1 = 1'b1;
      for (int g = 0; g < 4; g++) begin
        total++;
        if ({gnt0, gnt1, pad_cs} !== 3'b001) begin
          bad++;
          $display("FAIL rr_gap[%0d.%0d]: got gnt=%b%b cs=%b expected 00 1", k, g, gnt0, gnt1, pad_cs);
        end
        tick(1);
      end
    end
  endtask

  task automatic test_regrant_alone();
    // Port 0 owns here; it alone re-requests during the gap.
    req1 = 1'b0; req0 = 1'b0;
    tick(1);
    req0 = 1'b1;
    tick(3);
    total++;
    if ({gnt0, gnt1, busy} !== 3'b001) begin
      bad++;
      $display("FAIL regrant_gap_kept: got gnt=%b%b busy=%b expected 00 1", gnt0, gnt1, busy);
    end
    tick(1);
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL regrant_alone: got gnt=%b%b expected 10", gnt0, gnt1);
    end
  endtask

  task automatic test_reset_mid();
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    req1 = 1'b1;
    tick(1);
    cs1 = 1'b0;
    #1;
    total++;
    if ({gnt1, pad_cs} !== 2'b10) begin
      bad++;
      $display("FAIL mid_owner1: got gnt1=%b cs=%b expected 1 0", gnt1, pad_cs);
    end
    rst_n = 1'b0;
    tick(1);
    total++;
    if ({pad_cs, gnt1, busy} !== 3'b100) begin
      bad++;
      $display("FAIL mid_reset: got cs=%b gnt1=%b busy=%b expected 1 0 0", pad_cs, gnt1, busy);
    end
    rst_n = 1'b1; req0 = 1'b1; cs1 = 1'b1;
    tick(1);
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL mid_first_tie: got gnt=%b%b expected 10", gnt0, gnt1);
    end
  endtask

  task automatic test_gap1();
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick(1);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({b_gnt0, b_gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL g1_owner[%0d]: got gnt=%b%b expected %s", k, b_gnt0, b_gnt1,
                 (k % 2 == 0) ? "10" : "01");
      end
      if (k % 2 == 0) req0 = 1'b0; else req1 = 1'b0;
      tick(1);
      req0 = 1'b1; req1 = 1'b1;
      total++;
      if ({b_gnt0, b_gnt1, b_busy, b_pad_cs} !== 4'b0011) begin
        bad++;
        $display("FAIL g1_gap[%0d]: got gnt=%b%b busy=%b cs=%b expected 00 1 1",
                 k, b_gnt0, b_gnt1, b_busy, b_pad_cs);
      end
      tick(1);
    end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_isolation();
    test_no_preempt();
    test_round_robin();
    test_regrant_alone();
    test_reset_mid();
    test_gap1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
